run_ctrl: RTL and testbench

- Synthesizable run/reset sequencer and watchdog for the processor core.
- Holds the core in reset for a fixed number of cycles after system reset releases, then lets it run.
- While running, counts cycles and committed instructions. Watches the core's err and halt outputs.
- Closes the run as DONE after a pipeline drain, or as FAULT on error or timeout. Sits between the board-level clock/reset source and the core's reset input.

---
 rtl/run_ctrl.sv | 157 +++++++++++++++
 tb/tb_run_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run/reset sequencer and watchdog for the processor core.
// Holds the core in reset after system reset, lets it run, counts cycles
// and commits, and closes the run as DONE (after drain) or FAULT.
//
// state  | meaning
// -------+---------------------------------------------------------------
// HOLD   | core held in reset for HOLD_CYCLES edges after rst releases
// RUN    | core executing; err/halt/timeout watched, counters advance
// DRAIN  | halt seen; pipeline allowed DRAIN_CYCLES edges to empty
// DONE   | clean finish; counters frozen, core left out of reset
// FAULT  | err or timeout; core frozen in reset, code and counters held
module run_ctrl #(
    parameter int HOLD_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_CYCLES   = 100000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err,
    input  logic             halt,
    input  logic             instr_commit,
    input  logic             restart,
    output logic             core_rst,
    output logic             run,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] commit_count
);

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_RUN_ERR = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_DRN_ERR = 2'b11;

    localparam logic [7:0]       HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    // Compared at 64 bits so a budget beyond the counter range never aliases.
    localparam logic [63:0]      TMO_LAST   = 64'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    logic [2:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] com_q, com_d;
    logic             core_rst_q, core_rst_d;
    logic [CNT_W-1:0] cyc_inc, com_inc;

    // Saturating increments: counters stick at all-ones rather than wrap.
    always_comb begin
        cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_ONE;
        com_inc = (com_q == '1) ? com_q : com_q + CNT_ONE;
    end

    // Next-state, counter and fault-code logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        cyc_d   = cyc_q;
        com_d   = com_q;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                if (instr_commit) com_d = com_inc;
                if (err) begin
                    state_d = S_FAULT;
                    code_d  = CODE_RUN_ERR;
                end else if (halt) begin
                    state_d = S_DRAIN;
                    cnt_d   = 8'd0;
                end else if (64'(cyc_q) == TMO_LAST) begin
                    state_d = S_FAULT;
                    code_d  = CODE_TIMEOUT;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_inc;
                if (instr_commit) com_d = com_inc;
                if (err) begin
                    state_d = S_FAULT;
                    code_d  = CODE_DRN_ERR;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE, S_FAULT: begin
                if (restart) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'd0;
                    code_d  = CODE_NONE;
                    cyc_d   = CNT_ZERO;
                    com_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = 8'd0;
                code_d  = CODE_NONE;
                cyc_d   = CNT_ZERO;
                com_d   = CNT_ZERO;
            end
        endcase
        core_rst_d = (state_d == S_HOLD) || (state_d == S_FAULT);
    end

    // State and datapath registers; rst low aborts everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_HOLD;
            cnt_q      <= 8'd0;
            code_q     <= CODE_NONE;
            cyc_q      <= CNT_ZERO;
            com_q      <= CNT_ZERO;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            cyc_q      <= cyc_d;
            com_q      <= com_d;
            core_rst_q <= core_rst_d;
        end
    end

    // Status flags decode straight from the registered state.
    always_comb begin
        run          = (state_q == S_RUN) || (state_q == S_DRAIN);
        done         = (state_q == S_DONE);
        fault        = (state_q == S_FAULT);
        core_rst     = core_rst_q;
        fault_code   = code_q;
        cycle_count  = cyc_q;
        commit_count = com_q;
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenario table, hand sequences and random traffic
// against a behavioural model, on two differently parameterised instances.
module tb_run_ctrl;

    localparam int A_H = 2, A_D = 4, A_MX = 50,  A_W = 32;
    localparam int B_H = 3, B_D = 2, B_MX = 100, B_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, err, halt, commit, restart;

    logic           a_crst, a_run, a_done, a_fault;
    logic [1:0]     a_code;
    logic [A_W-1:0] a_cyc, a_com;
    logic           b_crst, b_run, b_done, b_fault;
    logic [1:0]     b_code;
    logic [B_W-1:0] b_cyc, b_com;

    run_ctrl #(.HOLD_CYCLES(A_H), .DRAIN_CYCLES(A_D), .MAX_CYCLES(A_MX), .CNT_W(A_W)) u_a (
        .clk(clk), .rst(rst), .err(err), .halt(halt), .instr_commit(commit),
        .restart(restart), .core_rst(a_crst), .run(a_run), .done(a_done),
        .fault(a_fault), .fault_code(a_code), .cycle_count(a_cyc), .commit_count(a_com));

    run_ctrl #(.HOLD_CYCLES(B_H), .DRAIN_CYCLES(B_D), .MAX_CYCLES(B_MX), .CNT_W(B_W)) u_b (
        .clk(clk), .rst(rst), .err(err), .halt(halt), .instr_commit(commit),
        .restart(restart), .core_rst(b_crst), .run(b_run), .done(b_done),
        .fault(b_fault), .fault_code(b_code), .cycle_count(b_cyc), .commit_count(b_com));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_HOLD = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_FAULT = 4;

    typedef struct {
        int     ph;
        int     hold_e;
        int     drain_e;
        longint cyc;
        longint com;
        int     code;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mreset();
        mst_t s;
        s.ph = P_HOLD; s.hold_e = 0; s.drain_e = 0; s.cyc = 0; s.com = 0; s.code = 0;
        return s;
    endfunction

    function automatic mst_t mstep(input mst_t s, input int h, input int d, input longint mx,
                                   input longint cmax, input bit e, input bit hl,
                                   input bit c, input bit r);
        mst_t   n;
        longint nxt;
        n = s;
        case (s.ph)
            P_HOLD: begin
                n.hold_e = s.hold_e + 1;
                if (n.hold_e >= h) n.ph = P_RUN;
            end
            P_RUN, P_DRAIN: begin
                nxt   = s.cyc + 1;
                n.cyc = (nxt > cmax) ? cmax : nxt;
                if (c) n.com = (s.com + 1 > cmax) ? cmax : s.com + 1;
                if (s.ph == P_RUN) begin
                    if (e) begin n.ph = P_FAULT; n.code = 1; end
                    else if (hl) begin n.ph = P_DRAIN; n.drain_e = 0; end
                    else if (nxt == mx) begin n.ph = P_FAULT; n.code = 2; end
                end else begin
                    if (e) begin n.ph = P_FAULT; n.code = 3; end
                    else begin
                        n.drain_e = s.drain_e + 1;
                        if (n.drain_e == d) n.ph = P_DONE;
                    end
                end
            end
            default: if (r) n = mreset();
        endcase
        return n;
    endfunction

    task automatic cmp_model(input string p, input mst_t m, input logic crst, input logic rn,
                             input logic dn, input logic ft, input logic [1:0] cd,
                             input logic [63:0] cy, input logic [63:0] cm);
        chk({p, ".core_rst"}, 64'(crst), 64'((m.ph == P_HOLD) || (m.ph == P_FAULT)));
        chk({p, ".run"},      64'(rn),   64'((m.ph == P_RUN) || (m.ph == P_DRAIN)));
        chk({p, ".done"},     64'(dn),   64'(m.ph == P_DONE));
        chk({p, ".fault"},    64'(ft),   64'(m.ph == P_FAULT));
        chk({p, ".code"},     64'(cd),   64'(m.code));
        chk({p, ".cycles"},   cy,        64'(m.cyc));
        chk({p, ".commits"},  cm,        64'(m.com));
    endtask

    task automatic check_models();
        cmp_model("A", ma, a_crst, a_run, a_done, a_fault, a_code, 64'(a_cyc), 64'(a_com));
        cmp_model("B", mb, b_crst, b_run, b_done, b_fault, b_code, 64'(b_cyc), 64'(b_com));
    endtask

    // One clock: model steps on the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = mstep(ma, A_H, A_D, A_MX, (64'd1 << A_W) - 1, err, halt, commit, restart);
            mb = mstep(mb, B_H, B_D, B_MX, (64'd1 << B_W) - 1, err, halt, commit, restart);
        end
        @(negedge clk);
        check_models();
    endtask

    task automatic drop_rst();
        rst = 1'b0;
        ma  = mreset();
        mb  = mreset();
    endtask

    task automatic chk_a_idle(input string nm);
        chk({nm, ".core_rst"}, 64'(a_crst), 64'd1);
        chk({nm, ".run"},      64'(a_run),  64'd0);
        chk({nm, ".done"},     64'(a_done), 64'd0);
        chk({nm, ".fault"},    64'(a_fault), 64'd0);
        chk({nm, ".code"},     64'(a_code), 64'd0);
        chk({nm, ".cycles"},   64'(a_cyc),  64'd0);
        chk({nm, ".commits"},  64'(a_com),  64'd0);
    endtask

    // ---------------- directed scenario table (instance A) ----------------
    typedef struct {
        string      nm;
        int         n_commit;
        int         halt_k;
        int         err_k;
        int         edges;
        bit         e_done;
        bit         e_fault;
        bit         e_crst;
        logic [1:0] e_code;
        int         e_cyc;
        int         e_com;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{"normal_halt",   10, 20,  0, 30, 1, 0, 0, 2'b00, 24, 10};
        vt[1] = '{"err_priority",   0,  5,  5, 10, 0, 1, 1, 2'b01,  5,  0};
        vt[2] = '{"timeout",        7,  0,  0, 60, 0, 1, 1, 2'b10, 50,  7};
        vt[3] = '{"drain_err",      3,  8, 10, 20, 0, 1, 1, 2'b11, 10,  3};
        vt[4] = '{"second_run",    10, 20,  0, 30, 1, 0, 0, 2'b00, 24, 10};
        vt[5] = '{"halt_first",     0,  1,  0, 10, 1, 0, 0, 2'b00,  5,  0};
        vt[6] = '{"halt_at_49",    60, 49,  0, 60, 1, 0, 0, 2'b00, 53, 53};
        vt[7] = '{"halt_beats_tmo", 0, 50,  0, 60, 1, 0, 0, 2'b00, 54,  0};
        vt[8] = '{"err_at_tmo",     0,  0, 50, 60, 0, 1, 1, 2'b01, 50,  0};
        vt[9] = '{"err_last_drain", 0, 10, 14, 20, 0, 1, 1, 2'b11, 14,  0};

        err = 0; halt = 0; commit = 0; restart = 0;
        drop_rst();

        // Reset release: low for 3 cycles, core released on the 2nd edge.
        repeat (3) tick();
        chk_a_idle("rst_hold");
        rst = 1'b1;
        tick();
        chk("rel_e1.core_rst", 64'(a_crst), 64'd1);
        chk("rel_e1.run",      64'(a_run),  64'd0);
        tick();
        chk("rel_e2.core_rst", 64'(a_crst), 64'd0);
        chk("rel_e2.run",      64'(a_run),  64'd1);
        chk("rel_e2.cycles",   64'(a_cyc),  64'd0);

        drop_rst();
        tick();
        rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            repeat (A_H) tick();
            for (int k = 1; k <= vt[v].edges; k++) begin
                commit = (k <= vt[v].n_commit);
                halt   = (k == vt[v].halt_k);
                err    = (k == vt[v].err_k);
                tick();
            end
            commit = 0; halt = 0; err = 0;
            chk({vt[v].nm, ".done"},     64'(a_done),  64'(vt[v].e_done));
            chk({vt[v].nm, ".fault"},    64'(a_fault), 64'(vt[v].e_fault));
            chk({vt[v].nm, ".run"},      64'(a_run),   64'd0);
            chk({vt[v].nm, ".core_rst"}, 64'(a_crst),  64'(vt[v].e_crst));
            chk({vt[v].nm, ".code"},     64'(a_code),  64'(vt[v].e_code));
            chk({vt[v].nm, ".cycles"},   64'(a_cyc),   64'(vt[v].e_cyc));
            chk({vt[v].nm, ".commits"},  64'(a_com),   64'(vt[v].e_com));
            restart = 1;
            tick();
            restart = 0;
            chk_a_idle({vt[v].nm, ".restart"});
        end

        // Asynchronous abort in the middle of a RUN cycle.
        repeat (A_H) tick();
        commit = 1;
        repeat (5) tick();
        chk("abort_pre.run", 64'(a_run), 64'd1);
        @(posedge clk);
        ma = mstep(ma, A_H, A_D, A_MX, (64'd1 << A_W) - 1, err, halt, commit, restart);
        mb = mstep(mb, B_H, B_D, B_MX, (64'd1 << B_W) - 1, err, halt, commit, restart);
        #3;
        drop_rst();
        #1;
        chk_a_idle("abort");
        check_models();
        @(negedge clk);
        commit = 0;
        tick();
        rst = 1'b1;

        // Saturation on the 4-bit instance.
        commit = 1;
        repeat (B_H) tick();
        repeat (30) tick();
        chk("sat.B.run",     64'(b_run), 64'd1);
        chk("sat.B.cycles",  64'(b_cyc), 64'd15);
        chk("sat.B.commits", 64'(b_com), 64'd15);
        halt = 1;
        tick();
        halt = 0;
        repeat (B_D) tick();
        commit = 0;
        chk("sat.B.done",    64'(b_done), 64'd1);
        chk("sat.B.cycles2", 64'(b_cyc),  64'd15);
        chk("sat.B.commits2", 64'(b_com), 64'd15);

        // Random traffic against the model.
        drop_rst();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            err     = ($urandom_range(99) < 3);
            halt    = ($urandom_range(99) < 5);
            commit  = ($urandom_range(99) < 50);
            restart = ($urandom_range(99) < 10);
            if ($urandom_range(299) == 0) drop_rst();
            else rst = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
